// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer scan controller.
// The bank bit sits above {row,col} in every RAM address.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  localparam int FB_MAX_AW = 32;

  function automatic int fb_addr_width(input int row_bits, input int col_bits);
    return 1 + row_bits + col_bits;
  endfunction

  function automatic logic [FB_MAX_AW-1:0] pack_addr(
    input logic                 bank,
    input logic [FB_MAX_AW-1:0] row,
    input logic [FB_MAX_AW-1:0] col,
    input int                   row_bits,
    input int                   col_bits
  );
    logic [FB_MAX_AW-1:0] a;
    a = (row << col_bits) | col;
    a = a | (FB_MAX_AW'(bank) << (row_bits + col_bits));
    return a;
  endfunction

endpackage

// File: rtl/fb_scan_addr_gen.sv
// Row/column scan counter: advances one pixel per issue, wraps at frame end.
// Flags describe the address currently presented for issue.
module fb_scan_addr_gen
  import fb_pkg::*;
#(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                issue,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                eol,
  output logic                eof,
  output logic                last_issue
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (issue) begin
      if (eol) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign eol        = &col;
  assign eof        = eol & (&row);
  assign last_issue = issue & eof;

endmodule

// File: rtl/fb_scan_ctrl.sv
// Double-buffered frame-buffer controller: host writes land in the back bank,
// the scan engine streams the front bank, banks swap only at frame boundaries.
module fb_scan_ctrl
  import fb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ROW_BITS   = 5,
  parameter  int COL_BITS   = 6,
  localparam int ADDR_WIDTH = fb_addr_width(ROW_BITS, COL_BITS),
  localparam int PIX_BITS   = ROW_BITS + COL_BITS,
  localparam int BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_en,
  input  logic [PIX_BITS-1:0]   host_addr,
  input  logic [BE_W-1:0]       host_we,
  input  logic [DATA_WIDTH-1:0] host_din,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  front_bank,
  input  logic                  scan_en,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic [ROW_BITS-1:0]   pixel_row,
  output logic [COL_BITS-1:0]   pixel_col,
  output logic                  pixel_eol,
  output logic                  pixel_eof,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  ram_a_en,
  output logic [ADDR_WIDTH-1:0] ram_a_addr,
  output logic [BE_W-1:0]       ram_a_we,
  output logic [DATA_WIDTH-1:0] ram_a_din,
  output logic                  ram_b_en,
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  input  logic [DATA_WIDTH-1:0] ram_b_dout
);

  fb_state_e             state, state_nxt;
  logic                  issue, acc, flip, gen_clr, swap_pending;
  logic [ROW_BITS-1:0]   gen_row;
  logic [COL_BITS-1:0]   gen_col;
  logic                  gen_eol, gen_eof, last_issue;

  fb_scan_addr_gen #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (gen_clr),
    .issue      (issue),
    .row        (gen_row),
    .col        (gen_col),
    .eol        (gen_eol),
    .eof        (gen_eof),
    .last_issue (last_issue)
  );

  // A read may issue whenever the output slot is empty or is draining this cycle.
  assign issue = (state == ST_SCAN) & (~pixel_valid | pixel_ready);
  assign acc   = pixel_valid & pixel_ready;

  always_comb begin
    state_nxt = state;
    gen_clr   = 1'b0;
    flip      = 1'b0;
    case (state)
      ST_IDLE: begin
        flip = swap_pending;
        if (scan_en) begin
          state_nxt = ST_SCAN;
          gen_clr   = 1'b1;
        end
      end
      ST_SCAN: begin
        if (last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (acc) begin
          flip      = swap_pending;
          state_nxt = scan_en ? ST_SCAN : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      swap_done    <= flip;
      // A request landing in the flip cycle survives for the next boundary.
      swap_pending <= (swap_pending & ~flip) | swap_req;
      if (flip) front_bank <= ~front_bank;
    end
  end

  // Sideband tracks the read in flight and holds with the RAM output on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pixel_row   <= '0;
      pixel_col   <= '0;
      pixel_eol   <= 1'b0;
      pixel_eof   <= 1'b0;
    end else if (issue) begin
      pixel_valid <= 1'b1;
      pixel_row   <= gen_row;
      pixel_col   <= gen_col;
      pixel_eol   <= gen_eol;
      pixel_eof   <= gen_eof;
    end else if (pixel_ready) begin
      pixel_valid <= 1'b0;
    end
  end

  assign pixel_data = ram_b_dout;
  assign ram_b_en   = issue;
  assign ram_b_addr = ADDR_WIDTH'(pack_addr(front_bank, FB_MAX_AW'(gen_row),
                                            FB_MAX_AW'(gen_col), ROW_BITS, COL_BITS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_a_en   <= 1'b0;
      ram_a_addr <= '0;
      ram_a_we   <= '0;
      ram_a_din  <= '0;
    end else begin
      ram_a_en   <= host_en;
      ram_a_addr <= {~front_bank, host_addr};
      ram_a_we   <= host_we;
      ram_a_din  <= host_din;
    end
  end

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Bench for fb_scan_ctrl with a small dual-port RAM model and a
// frame-level reference model checked every cycle.
module tb_fb_scan_ctrl;
  localparam int DW = 32, RB = 1, CB = 2, PB = 3, AW = 4, NPIX = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          host_en, swap_req, scan_en, pixel_ready;
  logic [PB-1:0] host_addr;
  logic [3:0]    host_we;
  logic [DW-1:0] host_din;
  logic          swap_done, front_bank, pixel_eol, pixel_eof, pixel_valid;
  logic [DW-1:0] pixel_data, ram_a_din, ram_b_dout;
  logic [RB-1:0] pixel_row;
  logic [CB-1:0] pixel_col;
  logic          ram_a_en, ram_b_en;
  logic [AW-1:0] ram_a_addr, ram_b_addr;
  logic [3:0]    ram_a_we;

  fb_scan_ctrl #(.DATA_WIDTH(DW), .ROW_BITS(RB), .COL_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .host_en(host_en), .host_addr(host_addr),
    .host_we(host_we), .host_din(host_din), .swap_req(swap_req),
    .swap_done(swap_done), .front_bank(front_bank), .scan_en(scan_en),
    .pixel_data(pixel_data), .pixel_row(pixel_row), .pixel_col(pixel_col),
    .pixel_eol(pixel_eol), .pixel_eof(pixel_eof), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .ram_a_en(ram_a_en), .ram_a_addr(ram_a_addr),
    .ram_a_we(ram_a_we), .ram_a_din(ram_a_din), .ram_b_en(ram_b_en),
    .ram_b_addr(ram_b_addr), .ram_b_dout(ram_b_dout)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte-enable write port A, registered hold-on-idle read port B
  logic [DW-1:0] mem     [0:2*NPIX-1];
  logic [DW-1:0] exp_mem [0:2*NPIX-1];
  always @(posedge clk) begin
    if (ram_a_en === 1'b1)
      for (int b = 0; b < 4; b++)
        if (ram_a_we[b]) mem[ram_a_addr][b*8 +: 8] <= ram_a_din[b*8 +: 8];
    if (ram_b_en === 1'b1) ram_b_dout <= mem[ram_b_addr];
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic          chk_en = 1'b0;
  logic          mdl_fb, mdl_pend, mdl_done, mdl_scan;
  int            k;
  logic          prev_stall, prev_hen, prev_fb;
  logic [DW-1:0] prev_data, prev_hdin;
  logic [RB-1:0] prev_row;
  logic [CB-1:0] prev_col;
  logic [PB-1:0] prev_haddr;
  logic [3:0]    prev_hwe;
  int            beats = 0, eol_cnt = 0, eof_cnt = 0, done_cnt = 0, stall_cnt = 0;
  int            frames_done = 0, first_acc_cyc = 0, eof_acc_cyc = 0, done_cyc = 0;
  logic [DW-1:0] first_data;

  always @(negedge clk) begin
    logic acc, lastb, flip;
    acc = (pixel_valid === 1'b1) && (pixel_ready === 1'b1);
    if (chk_en) begin
      chk("front_bank", front_bank, mdl_fb);
      chk("swap_done", swap_done, mdl_done);
      chk("ram_a_en", ram_a_en, prev_hen);
      if (prev_hen) begin
        chk("ram_a_addr", ram_a_addr, {~prev_fb, prev_haddr});
        chk("ram_a_we", ram_a_we, prev_hwe);
        chk("ram_a_din", ram_a_din, prev_hdin);
      end
      if (prev_stall) begin
        chk("stall_valid", pixel_valid, 1'b1);
        chk("stall_data", pixel_data, prev_data);
        chk("stall_pos", {pixel_row, pixel_col}, {prev_row, prev_col});
      end
      if (pixel_valid === 1'b1 && !pixel_ready) chk("stall_ram_b_en", ram_b_en, 1'b0);
      if (ram_b_en === 1'b1) chk("read_bank", ram_b_addr[AW-1], mdl_fb);
      if (swap_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (rst_n && pixel_valid === 1'b1 && !pixel_ready) stall_cnt++;
      if (rst_n && acc) begin
        chk("beat_data", pixel_data, exp_mem[{mdl_fb, 3'(k)}]);
        chk("beat_row", pixel_row, k / 4);
        chk("beat_col", pixel_col, k % 4);
        chk("beat_eol", pixel_eol, (k % 4) == 3);
        chk("beat_eof", pixel_eof, k == NPIX - 1);
        beats++;
        if (pixel_eol) eol_cnt++;
        if (pixel_eof) eof_cnt++;
        if (k == 0) begin first_acc_cyc = cyc; first_data = pixel_data; end
        if (k == NPIX - 1) begin eof_acc_cyc = cyc; frames_done++; end
      end
    end
    if (!rst_n) begin
      mdl_fb = 0; mdl_pend = 0; mdl_done = 0; mdl_scan = 0; k = 0;
      prev_stall = 0; prev_hen = 0;
    end else begin
      lastb      = acc && (k == NPIX - 1);
      flip       = mdl_pend && (!mdl_scan || lastb);
      prev_stall = (pixel_valid === 1'b1) && !pixel_ready;
      prev_data  = pixel_data; prev_row = pixel_row; prev_col = pixel_col;
      prev_hen   = host_en; prev_haddr = host_addr; prev_hwe = host_we;
      prev_hdin  = host_din; prev_fb = mdl_fb;
      if (acc) k = (k + 1) % NPIX;
      mdl_scan = mdl_scan ? !(lastb && !scan_en) : scan_en;
      mdl_pend = (mdl_pend && !flip) || swap_req;
      mdl_done = flip;
      if (flip) mdl_fb = !mdl_fb;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 60) begin step(1); n++; end
    chk("frame_timeout", frames_done >= target, 1'b1);
  endtask

  initial begin
    int c0;
    logic [13:0] rdy_pat;
    scan_en = 0; pixel_ready = 1; swap_req = 0;
    host_en = 0; host_addr = '0; host_we = '0; host_din = '0;
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = i; mem[NPIX+i] = 32'h100 + i;
      exp_mem[i] = i; exp_mem[NPIX+i] = 32'h100 + i;
    end
    step(3);
    rst_n = 1; chk_en = 1;
    chk("rst_valid", pixel_valid, 0); chk("rst_front", front_bank, 0);
    chk("rst_done", swap_done, 0); chk("rst_a_en", ram_a_en, 0);
    chk("rst_b_en", ram_b_en, 0); chk("rst_b_addr", ram_b_addr, 0);
    chk("rst_pos", {pixel_row, pixel_col, pixel_eol, pixel_eof}, 0);

    // Host writes go to the back bank (bank 1 while front is 0)
    host_en = 1; host_addr = 3'd0; host_din = 32'hA5A5A5A5; host_we = 4'hF;
    step(1);
    chk("wr0_en", ram_a_en, 1); chk("wr0_addr", ram_a_addr, 4'h8);
    chk("wr0_din", ram_a_din, 32'hA5A5A5A5);
    exp_mem[8] = 32'hA5A5A5A5;
    host_addr = 3'd5; host_din = 32'hDEADBEEF; host_we = 4'b0011;
    step(1);
    chk("wr1_addr", ram_a_addr, 4'hD); chk("wr1_we", ram_a_we, 4'b0011);
    exp_mem[13] = 32'h0000BEEF;
    host_en = 0; host_we = '0;
    step(1);
    chk("wr_idle", ram_a_en, 0);

    // Frame 1: full rate; scan_en dropped mid-frame must not truncate
    c0 = cyc; scan_en = 1;
    step(3); scan_en = 0;
    wait_frames(1);
    chk("f1_first_lat", first_acc_cyc - c0, 2);
    chk("f1_eof_lat", eof_acc_cyc - c0, 9);
    chk("f1_first_data", first_data, 0);
    chk("f1_beats", beats, 8); chk("f1_eol", eol_cnt, 2); chk("f1_eof", eof_cnt, 1);
    step(5);
    chk("f1_no_restart", beats, 8); chk("f1_idle_valid", pixel_valid, 0);

    // Frame 2: mid-row stall, two swap requests -> one swap at frame end
    rdy_pat = ~14'b00_0001_1000_0000;
    c0 = cyc; scan_en = 1;
    for (int i = 0; i < 14; i++) begin
      pixel_ready = rdy_pat[i];
      swap_req = (i == 4 || i == 7);
      if (i == 11) chk("f2_front_hold", front_bank, 0);
      step(1);
    end
    pixel_ready = 1; swap_req = 0;
    chk("f2_stalls", stall_cnt, 2);
    chk("f2_eof_lat", eof_acc_cyc - c0, 11);
    chk("f2_done_cyc", done_cyc - c0, 12);
    chk("f2_done_cnt", done_cnt, 1);
    chk("f2_front", front_bank, 1);

    // Frame 3 runs back to back from bank 1
    scan_en = 0;
    wait_frames(3);
    chk("f3_first_data", first_data, 32'hA5A5A5A5);
    chk("f3_beats", beats, 24);
    step(3);

    // Reset mid-frame with a pending swap and a write in the reset cycle
    scan_en = 1;
    step(4);
    swap_req = 1; step(1); swap_req = 0;
    rst_n = 0; host_en = 1; host_addr = 3'd2; host_we = 4'hF; host_din = 32'h12345678;
    step(1);
    rst_n = 1; host_en = 0; host_we = '0;
    chk("mr_valid", pixel_valid, 0); chk("mr_front", front_bank, 0);
    chk("mr_a_en", ram_a_en, 0); chk("mr_b_en", ram_b_en, 0);
    chk("mr_pos", {pixel_row, pixel_col, pixel_eol, pixel_eof, swap_done}, 0);
    chk("mr_a_addr", ram_a_addr, 0); chk("mr_b_addr", ram_b_addr, 0);
    c0 = cyc;
    step(2); scan_en = 0;
    wait_frames(4);
    chk("f4_first_lat", first_acc_cyc - c0, 2);
    chk("f4_first_data", first_data, 0);
    chk("f4_front", front_bank, 0);
    step(3);

    // Idle swap: request -> pending -> flip
    swap_req = 1; step(1); swap_req = 0;
    chk("idle_front_a", front_bank, 0);
    step(1);
    chk("idle_front_b", front_bank, 1); chk("idle_done", swap_done, 1);
    step(1);
    chk("idle_done_off", swap_done, 0); chk("idle_done_cnt", done_cnt, 2);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
